axis_pl_to_ps_gearbox: RTL and testbench
========================================

Name: axis_pl_to_ps_gearbox

Overview:
Parametrised successor to the fixed 128-to-32 PL-to-PS path. It takes wide AXI-Stream words from the ADC control path and splits each one into RATIO = IN_WIDTH/OUT_WIDTH narrow beats, lowest slice first. The beats are buffered in an internal first-word-fall-through FIFO and presented to the PS DMA. Compared with the previous block it adds:
- generic widths and FIFO depth;
- full-throughput back-to-back acceptance;
- programmable packet framing via m_axis_tlast;
- a FIFO level output and a packet counter.

Parameters:
IN_WIDTH, 128, input word width; must be an integer multiple of OUT_WIDTH.
OUT_WIDTH, 32, output beat width to the PS.
FIFO_DEPTH, 16, output FIFO entries; power of 2, at least 2.
RATIO, IN_WIDTH/OUT_WIDTH, derived localparam; not overridable.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
s_axis_tdata  in  IN_WIDTH  wide word from the ADC control path
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
m_axis_tdata  out  OUT_WIDTH  beat to the PS
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  PS ready
m_axis_tlast  out  1  last beat of a packet
enable  in  1  readout enable; gates input acceptance only
flush  in  1  synchronous level flush
pkt_len  in  16  output beats per packet; 0 means tlast is never asserted
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
pkt_count  out  32  packets completed (tlast beats accepted by the PS), wraps at 2^32

Behaviour:
- Reset (rst low, asynchronous): clear the word buffer, buf_valid, slice_idx, the beat counter, the latched packet length, FIFO pointers and pkt_count.
  - All outputs are 0: s_axis_tready, m_axis_tvalid, m_axis_tlast, fifo_level, pkt_count, m_axis_tdata.
  - Reset asserted mid-word discards the partial word; there is no recovery of it.
- Input acceptance:
  - s_axis_tready = enable && !flush && (!buf_valid || (slice_idx==RATIO-1 && !fifo_full)). This is combinational from registers and inputs.
  - A transfer occurs when s_axis_tvalid && s_axis_tready. On that edge the word is loaded into the buffer, buf_valid=1 and slice_idx=0.
- Slicing:
  - While buf_valid && !fifo_full, each clock pushes word[slice_idx*OUT_WIDTH +: OUT_WIDTH] into the FIFO and increments slice_idx.
  - On the push of slice RATIO-1: buf_valid clears, unless a new word is accepted on the same edge, in which case the buffer reloads and slice_idx returns to 0.
  - This gives a sustained rate of one input word per RATIO clocks with no bubble.
  - When the FIFO is full, slicing stalls and the buffer and slice_idx hold.
- RATIO==1: the block degenerates to pass-through into the FIFO. tready = enable && !flush && !fifo_full whenever buf_valid would clear on the same edge.
- Framing:
  - The beat counter counts FIFO pushes.
  - The pushed beat carries tlast=1 when pkt_len!=0 and count==latched_len-1; the counter then returns to 0.
  - pkt_len is latched only when count==0, so changes mid-packet take effect at the next packet.
  - The tlast bit is stored in the FIFO alongside the data.
- FIFO:
  - Storage is FIFO_DEPTH x (OUT_WIDTH+1), first-word fall-through.
  - m_axis_tvalid = !empty. m_axis_tdata and m_axis_tlast show the head entry.
  - Pop on m_axis_tvalid && m_axis_tready.
  - A simultaneous push and pop at full or empty is legal; the level stays constant.
  - fifo_level is exact and registered.
- Latency: a word accepted at edge E0 pushes slice 0 at E1. m_axis_tvalid is high in the cycle after E1, i.e. 2 clocks after acceptance.
- pkt_count increments on a pop of a beat with tlast=1.
- Flush (level, synchronous):
  - While high, s_axis_tready=0, the buffer is dropped, the FIFO is emptied (m_axis_tvalid=0 the cycle after flush first samples high) and the beat counter is cleared.
  - pkt_count is not cleared.
  - Flush has priority over simultaneous push, pop and accept.
- Enable low mid-word: the current buffered word still finishes slicing and draining. Only new acceptance is blocked.

Test Plan:
- Single word, defaults: input 0x44444444_33333333_22222222_11111111 with m_axis_tready=1 -> beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 on 4 consecutive cycles. First beat appears 2 clocks after acceptance.
- Throughput: 64 back-to-back words with tready held high -> 256 output beats with no gaps. s_axis_tready is high exactly once per 4 cycles after the first word, and data order is preserved.
- Backpressure: m_axis_tready=0 while 8 words are offered -> fifo_level reaches 16 and s_axis_tready stays 0. Release tready -> all 32 beats are delivered intact; no loss or duplication.
- Framing: pkt_len=6 with 6 words -> tlast on beats 6, 12, 18 and 24, and pkt_count=4. Change pkt_len to 3 at beat 8 -> no change until beat 12; tlast then falls on 15, 18, 21, 24.
- Flush mid-word: accept a word, assert flush for 1 cycle after slice 1 is pushed -> m_axis_tvalid=0, fifo_level=0 and the beat counter=0. pkt_count is unchanged, and the next word starts at its slice 0.
- Reset mid-stream: pull rst low with the FIFO holding 10 beats -> all outputs are 0 immediately. After release, the first new word is output cleanly. Repeat with IN_WIDTH=64 and OUT_WIDTH=64 (RATIO=1) as the pass-through check.

Source files
------------

// File: rtl/axis_pl_to_ps_gearbox.sv
// axis_pl_to_ps_gearbox
// Splits wide AXI-Stream words from the ADC control path into RATIO narrow
// beats (lowest slice first), tags packet boundaries with a programmable
// tlast, and buffers the beats in a first-word-fall-through FIFO for the PS DMA.
module axis_pl_to_ps_gearbox #(
  parameter int IN_WIDTH   = 128,
  parameter int OUT_WIDTH  = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [IN_WIDTH-1:0]         s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [OUT_WIDTH-1:0]        m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  input  logic                        enable,
  input  logic                        flush,
  input  logic [15:0]                 pkt_len,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [31:0]                 pkt_count
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(RATIO - 1);
  localparam logic [LW-1:0]    FULL_LEVEL = LW'(FIFO_DEPTH);

  // Word buffer and slice selection
  logic [IN_WIDTH-1:0]  buf_word;
  logic                 buf_valid;
  logic [IDX_W-1:0]     slice_idx;
  logic [OUT_WIDTH-1:0] cur_slice;
  logic                 last_slice;

  // Handshake qualifiers
  logic accept;
  logic push;
  logic pop;

  // Packet framing
  logic [15:0] beat_cnt;
  logic [15:0] len_q;
  logic [15:0] eff_len;
  logic        push_last;

  // FIFO storage: {tlast, data}
  logic [OUT_WIDTH:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [LW-1:0]      level;
  logic               fifo_full;
  logic               fifo_empty;
  logic [OUT_WIDTH:0] head;

  assign fifo_full  = (level == FULL_LEVEL);
  assign fifo_empty = (level == '0);
  assign last_slice = (slice_idx == LAST_IDX);

  // A new word may enter when the buffer is free, or when the final slice
  // leaves on this same edge so the next word follows without a bubble.
  // Gating with rst keeps tready low while reset is held.
  assign s_axis_tready = rst && enable && !flush &&
                         (!buf_valid || (last_slice && !fifo_full));
  assign accept        = s_axis_tvalid && s_axis_tready;

  // Flush overrides push and pop so the FIFO ends up empty.
  assign push = buf_valid && !fifo_full && !flush;
  assign pop  = !fifo_empty && m_axis_tready && !flush;

  // Select the slice currently addressed by slice_idx
  always_comb begin
    cur_slice = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (slice_idx == IDX_W'(i)) begin
        cur_slice = buf_word[i*OUT_WIDTH +: OUT_WIDTH];
      end
    end
  end

  // Word buffer: load on accept, walk through slices as the FIFO takes them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_word  <= '0;
      buf_valid <= 1'b0;
      slice_idx <= '0;
    end else if (flush) begin
      buf_valid <= 1'b0;
      slice_idx <= '0;
    end else if (accept) begin
      buf_word  <= s_axis_tdata;
      buf_valid <= 1'b1;
      slice_idx <= '0;
    end else if (push) begin
      if (last_slice) begin
        buf_valid <= 1'b0;
      end else begin
        slice_idx <= slice_idx + IDX_W'(1);
      end
    end
  end

  // The packet length in force is sampled at the start of each packet, so a
  // mid-packet change of pkt_len only applies from the next packet onward.
  assign eff_len   = (beat_cnt == 16'd0) ? pkt_len : len_q;
  assign push_last = (eff_len != 16'd0) && (beat_cnt == eff_len - 16'd1);

  // Beat counter and latched packet length; a zero length keeps the counter
  // parked at 0 so a newly programmed length takes effect immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt <= '0;
      len_q    <= '0;
    end else if (flush) begin
      beat_cnt <= '0;
      len_q    <= '0;
    end else if (push) begin
      if (beat_cnt == 16'd0) begin
        len_q <= pkt_len;
      end
      if (push_last || (eff_len == 16'd0)) begin
        beat_cnt <= '0;
      end else begin
        beat_cnt <= beat_cnt + 16'd1;
      end
    end
  end

  // FIFO storage write; data words carry no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {push_last, cur_slice};
    end
  end

  // FIFO pointers and exact occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Completed packets: tlast beats taken by the PS
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_count <= '0;
    end else if (pop && head[OUT_WIDTH]) begin
      pkt_count <= pkt_count + 32'd1;
    end
  end

  // Head of the FIFO is presented directly; zeroed while empty so stale
  // storage never shows on the bus.
  assign head          = mem[rd_ptr];
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : head[OUT_WIDTH-1:0];
  assign m_axis_tlast  = !fifo_empty && head[OUT_WIDTH];
  assign fifo_level    = level;

endmodule

// File: tb/tb_axis_pl_to_ps_gearbox.sv
// Directed bench for axis_pl_to_ps_gearbox: a 128->32 instance and a 64->64
// pass-through instance sharing clock and reset.
module tb_axis_pl_to_ps_gearbox;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 128 -> 32 instance
  logic [127:0] s_data;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  m_data;
  logic         m_valid;
  logic         m_ready;
  logic         m_last;
  logic         enable;
  logic         flush;
  logic [15:0]  pkt_len;
  logic [4:0]   level;
  logic [31:0]  pkt_count;

  // 64 -> 64 pass-through instance
  logic [63:0]  s1_data;
  logic         s1_valid;
  logic         s1_ready;
  logic [63:0]  m1_data;
  logic         m1_valid;
  logic         m1_ready;
  logic         m1_last;
  logic         enable1;
  logic         flush1;
  logic [15:0]  pkt_len1;
  logic [4:0]   level1;
  logic [31:0]  pkt_count1;

  int checks = 0;
  int passed = 0;

  axis_pl_to_ps_gearbox #(.IN_WIDTH(128), .OUT_WIDTH(32), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .m_axis_tlast(m_last), .enable(enable), .flush(flush), .pkt_len(pkt_len),
    .fifo_level(level), .pkt_count(pkt_count)
  );

  axis_pl_to_ps_gearbox #(.IN_WIDTH(64), .OUT_WIDTH(64), .FIFO_DEPTH(16)) dut1 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s1_data), .s_axis_tvalid(s1_valid), .s_axis_tready(s1_ready),
    .m_axis_tdata(m1_data), .m_axis_tvalid(m1_valid), .m_axis_tready(m1_ready),
    .m_axis_tlast(m1_last), .enable(enable1), .flush(flush1), .pkt_len(pkt_len1),
    .fifo_level(level1), .pkt_count(pkt_count1)
  );

  // Wide word whose four slices are b, b+1, b+2, b+3 from the low end
  function automatic logic [127:0] mkword(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    s_valid = 1'b1; s_data = mkword(32'h5555_0000); m_ready = 1'b1;
    s1_valid = 1'b1; s1_data = 64'h1234_5678_9ABC_DEF0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (s_ready !== 1'b0) $display("FAIL rst_tready: got %b expected 0", s_ready); else passed++;
    checks++; if (m_valid !== 1'b0) $display("FAIL rst_tvalid: got %b expected 0", m_valid); else passed++;
    checks++; if (m_last !== 1'b0) $display("FAIL rst_tlast: got %b expected 0", m_last); else passed++;
    checks++; if (level !== 5'd0) $display("FAIL rst_level: got %0d expected 0", level); else passed++;
    checks++; if (pkt_count !== 32'd0) $display("FAIL rst_pkt_count: got %0d expected 0", pkt_count); else passed++;
    checks++; if (m_data !== 32'd0) $display("FAIL rst_tdata: got %h expected 0", m_data); else passed++;
    checks++; if (s1_ready !== 1'b0) $display("FAIL rst_tready_r1: got %b expected 0", s1_ready); else passed++;
    checks++; if (m1_valid !== 1'b0) $display("FAIL rst_tvalid_r1: got %b expected 0", m1_valid); else passed++;
    s_valid = 1'b0; s1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b1) $display("FAIL rst_release_tready: got %b expected 1", s_ready); else passed++;
  endtask

  task automatic test_single_word();
    logic [31:0] exp_beat [4];
    exp_beat = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    @(negedge clk);
    s_data = 128'h44444444_33333333_22222222_11111111; s_valid = 1'b1; m_ready = 1'b1;
    #3;
    checks++; if (s_ready !== 1'b1) $display("FAIL single_tready: got %b expected 1", s_ready); else passed++;
    @(negedge clk);
    s_valid = 1'b0;
    #3;
    checks++; if (m_valid !== 1'b0) $display("FAIL single_latency: tvalid got %b expected 0 one clock after accept", m_valid); else passed++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #3;
      checks++;
      if ({m_valid, m_last, m_data} !== {1'b1, 1'b0, exp_beat[k]})
        $display("FAIL single_beat%0d: got v=%b l=%b d=%h expected v=1 l=0 d=%h", k, m_valid, m_last, m_data, exp_beat[k]);
      else passed++;
    end
    @(negedge clk); #3;
    checks++; if (m_valid !== 1'b0) $display("FAIL single_drain: tvalid got %b expected 0", m_valid); else passed++;
  endtask

  task automatic test_enable();
    int beats = 0;
    int errs = 0;
    int rdy = 0;
    @(negedge clk);
    s_data = mkword(32'h6000_0000); s_valid = 1'b1; enable = 1'b1; m_ready = 1'b1;
    #3;
    @(negedge clk);
    s_data = mkword(32'h6100_0000); enable = 1'b0;
    #3;
    checks++; if (s_ready !== 1'b0) $display("FAIL enable_tready: got %b expected 0", s_ready); else passed++;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #3;
      if (s_ready) rdy++;
      if (m_valid) begin
        if (m_data !== 32'h6000_0000 + 32'(beats)) errs++;
        beats++;
      end
    end
    s_valid = 1'b0; enable = 1'b1;
    checks++; if (beats !== 4) $display("FAIL enable_beats: got %0d expected 4", beats); else passed++;
    checks++; if (errs !== 0) $display("FAIL enable_data: got %0d bad beats expected 0", errs); else passed++;
    checks++; if (rdy !== 0) $display("FAIL enable_blocked: tready high %0d cycles expected 0", rdy); else passed++;
  endtask

  task automatic test_throughput();
    int widx = 0;
    int bidx = 0;
    int errs = 0;
    int gaps = 0;
    int sp_errs = 0;
    int last_acc = -1;
    int cyc = 0;
    bit started = 1'b0;
    m_ready = 1'b1;
    while (bidx < 256 && cyc < 2000) begin
      @(negedge clk);
      s_valid = (widx < 64);
      s_data = mkword(32'hA000_0000 + 32'(widx * 4));
      #3;
      if (s_valid && s_ready) begin
        if (last_acc >= 0 && (cyc - last_acc) != 4) sp_errs++;
        last_acc = cyc;
        widx++;
      end
      if (m_valid) begin
        if (m_data !== 32'hA000_0000 + 32'(bidx)) errs++;
        bidx++;
        started = 1'b1;
      end else if (started) begin
        gaps++;
      end
      cyc++;
    end
    s_valid = 1'b0;
    checks++; if (widx !== 64) $display("FAIL tp_words: got %0d accepted expected 64", widx); else passed++;
    checks++; if (bidx !== 256) $display("FAIL tp_beats: got %0d expected 256", bidx); else passed++;
    checks++; if (errs !== 0) $display("FAIL tp_order: got %0d bad beats expected 0", errs); else passed++;
    checks++; if (gaps !== 0) $display("FAIL tp_gaps: got %0d idle cycles expected 0", gaps); else passed++;
    checks++; if (sp_errs !== 0) $display("FAIL tp_ready_spacing: got %0d irregular accepts expected 0", sp_errs); else passed++;
    @(negedge clk); #3;
    checks++; if (level !== 5'd0) $display("FAIL tp_drained: level got %0d expected 0", level); else passed++;
  endtask

  task automatic test_backpressure();
    int widx = 0;
    int bidx = 0;
    int errs = 0;
    int ready_full = 0;
    m_ready = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      s_valid = (widx < 8);
      s_data = mkword(32'hB000_0000 + 32'(widx * 4));
      #3;
      if (level == 5'd16 && s_ready) ready_full++;
      if (s_valid && s_ready) widx++;
    end
    checks++; if (level !== 5'd16) $display("FAIL bp_level: got %0d expected 16", level); else passed++;
    checks++; if (s_ready !== 1'b0) $display("FAIL bp_tready: got %b expected 0", s_ready); else passed++;
    checks++; if (widx !== 5) $display("FAIL bp_accepted: got %0d expected 5", widx); else passed++;
    checks++; if (ready_full !== 0) $display("FAIL bp_ready_at_full: got %0d expected 0", ready_full); else passed++;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      m_ready = 1'b1;
      s_valid = (widx < 8);
      s_data = mkword(32'hB000_0000 + 32'(widx * 4));
      #3;
      if (s_valid && s_ready) widx++;
      if (m_valid) begin
        if (m_data !== 32'hB000_0000 + 32'(bidx)) errs++;
        bidx++;
      end
    end
    s_valid = 1'b0;
    checks++; if (bidx !== 32) $display("FAIL bp_beats: got %0d expected 32", bidx); else passed++;
    checks++; if (errs !== 0) $display("FAIL bp_data: got %0d bad beats expected 0", errs); else passed++;
    checks++; if (widx !== 8) $display("FAIL bp_all_words: got %0d expected 8", widx); else passed++;
    checks++; if (level !== 5'd0) $display("FAIL bp_final_level: got %0d expected 0", level); else passed++;
  endtask

  task automatic test_framing();
    int widx;
    int bidx;
    int errs;
    int lerr;
    int cyc;
    bit switched;
    bit exp_l;
    logic [31:0] p0;
    // fixed length 6
    widx = 0; bidx = 0; errs = 0; lerr = 0; cyc = 0;
    p0 = pkt_count; pkt_len = 16'd6; m_ready = 1'b1;
    while (bidx < 24 && cyc < 300) begin
      @(negedge clk);
      s_valid = (widx < 6);
      s_data = mkword(32'hC000_0000 + 32'(widx * 4));
      #3;
      if (s_valid && s_ready) widx++;
      if (m_valid) begin
        if (m_data !== 32'hC000_0000 + 32'(bidx)) errs++;
        bidx++;
        exp_l = (bidx % 6 == 0);
        if (m_last !== exp_l) lerr++;
      end
      cyc++;
    end
    s_valid = 1'b0;
    @(negedge clk); #3;
    checks++; if (bidx !== 24) $display("FAIL frame6_beats: got %0d expected 24", bidx); else passed++;
    checks++; if (errs !== 0) $display("FAIL frame6_data: got %0d bad beats expected 0", errs); else passed++;
    checks++; if (lerr !== 0) $display("FAIL frame6_tlast: got %0d misplaced tlast expected 0", lerr); else passed++;
    checks++; if (pkt_count !== p0 + 32'd4) $display("FAIL frame6_pkt_count: got %0d expected %0d", pkt_count, p0 + 32'd4); else passed++;
    // length changed to 3 after beat 8
    widx = 0; bidx = 0; errs = 0; lerr = 0; cyc = 0; switched = 1'b0;
    p0 = pkt_count; pkt_len = 16'd6;
    while (bidx < 24 && cyc < 300) begin
      @(negedge clk);
      if (bidx >= 8 && !switched) begin
        pkt_len = 16'd3;
        switched = 1'b1;
      end
      s_valid = (widx < 6);
      s_data = mkword(32'hC100_0000 + 32'(widx * 4));
      #3;
      if (s_valid && s_ready) widx++;
      if (m_valid) begin
        if (m_data !== 32'hC100_0000 + 32'(bidx)) errs++;
        bidx++;
        exp_l = (bidx == 6) || (bidx == 12) || (bidx == 15) || (bidx == 18) || (bidx == 21) || (bidx == 24);
        if (m_last !== exp_l) lerr++;
      end
      cyc++;
    end
    s_valid = 1'b0;
    @(negedge clk); #3;
    pkt_len = 16'd0;
    checks++; if (bidx !== 24) $display("FAIL frame3_beats: got %0d expected 24", bidx); else passed++;
    checks++; if (errs !== 0) $display("FAIL frame3_data: got %0d bad beats expected 0", errs); else passed++;
    checks++; if (lerr !== 0) $display("FAIL frame3_tlast: got %0d misplaced tlast expected 0", lerr); else passed++;
    checks++; if (pkt_count !== p0 + 32'd6) $display("FAIL frame3_pkt_count: got %0d expected %0d", pkt_count, p0 + 32'd6); else passed++;
  endtask

  task automatic test_flush();
    logic [31:0] p0;
    int beats = 0;
    int errs = 0;
    int lerr = 0;
    logic [31:0] first = 32'hFFFF_FFFF;
    p0 = pkt_count; pkt_len = 16'd3; m_ready = 1'b0;
    @(negedge clk);
    s_data = mkword(32'hD000_0000); s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (level !== 5'd2) $display("FAIL flush_pre_level: got %0d expected 2", level); else passed++;
    flush = 1'b1; s_valid = 1'b1; s_data = mkword(32'hE000_0000);
    #2;
    checks++; if (s_ready !== 1'b0) $display("FAIL flush_tready: got %b expected 0", s_ready); else passed++;
    @(negedge clk);
    flush = 1'b0; m_ready = 1'b1;
    #3;
    checks++; if (m_valid !== 1'b0) $display("FAIL flush_tvalid: got %b expected 0", m_valid); else passed++;
    checks++; if (level !== 5'd0) $display("FAIL flush_level: got %0d expected 0", level); else passed++;
    checks++; if (pkt_count !== p0) $display("FAIL flush_pkt_count: got %0d expected %0d", pkt_count, p0); else passed++;
    checks++; if (s_ready !== 1'b1) $display("FAIL flush_buffer_dropped: tready got %b expected 1", s_ready); else passed++;
    @(negedge clk);
    s_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #3;
      if (m_valid) begin
        if (beats == 0) first = m_data;
        if (m_data !== 32'hE000_0000 + 32'(beats)) errs++;
        if (m_last !== (beats == 2)) lerr++;
        beats++;
      end
    end
    pkt_len = 16'd0;
    checks++; if (first !== 32'hE000_0000) $display("FAIL flush_next_first: got %h expected e0000000", first); else passed++;
    checks++; if (beats !== 4) $display("FAIL flush_next_beats: got %0d expected 4", beats); else passed++;
    checks++; if (errs !== 0) $display("FAIL flush_next_data: got %0d bad beats expected 0", errs); else passed++;
    checks++; if (lerr !== 0) $display("FAIL flush_counter_cleared: got %0d misplaced tlast expected 0", lerr); else passed++;
    checks++; if (pkt_count !== p0 + 32'd1) $display("FAIL flush_next_pkt_count: got %0d expected %0d", pkt_count, p0 + 32'd1); else passed++;
  endtask

  task automatic test_reset_midstream();
    int widx = 0;
    int cyc = 0;
    int beats = 0;
    int errs = 0;
    logic [31:0] first = 32'hFFFF_FFFF;
    m_ready = 1'b0; pkt_len = 16'd0;
    while (level != 5'd10 && cyc < 100) begin
      @(negedge clk);
      s_valid = (widx < 4);
      s_data = mkword(32'h7000_0000 + 32'(widx * 4));
      #3;
      if (level != 5'd10 && s_valid && s_ready) widx++;
      cyc++;
    end
    checks++; if (level !== 5'd10) $display("FAIL rm_fill_level: got %0d expected 10", level); else passed++;
    rst = 1'b0;
    #1;
    checks++; if (s_ready !== 1'b0) $display("FAIL rm_tready: got %b expected 0", s_ready); else passed++;
    checks++; if (m_valid !== 1'b0) $display("FAIL rm_tvalid: got %b expected 0", m_valid); else passed++;
    checks++; if (m_last !== 1'b0) $display("FAIL rm_tlast: got %b expected 0", m_last); else passed++;
    checks++; if (level !== 5'd0) $display("FAIL rm_level: got %0d expected 0", level); else passed++;
    checks++; if (pkt_count !== 32'd0) $display("FAIL rm_pkt_count: got %0d expected 0", pkt_count); else passed++;
    checks++; if (m_data !== 32'd0) $display("FAIL rm_tdata: got %h expected 0", m_data); else passed++;
    s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    s_data = mkword(32'h8000_0000); s_valid = 1'b1; m_ready = 1'b1;
    #3;
    checks++; if (s_ready !== 1'b1) $display("FAIL rm_post_tready: got %b expected 1", s_ready); else passed++;
    @(negedge clk);
    s_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #3;
      if (m_valid) begin
        if (beats == 0) first = m_data;
        if (m_data !== 32'h8000_0000 + 32'(beats)) errs++;
        beats++;
      end
    end
    checks++; if (first !== 32'h8000_0000) $display("FAIL rm_post_first: got %h expected 80000000", first); else passed++;
    checks++; if (beats !== 4) $display("FAIL rm_post_beats: got %0d expected 4", beats); else passed++;
    checks++; if (errs !== 0) $display("FAIL rm_post_data: got %0d bad beats expected 0", errs); else passed++;
  endtask

  task automatic test_passthrough();
    logic [63:0] pw [4];
    int widx = 0;
    int cyc = 0;
    pw = '{64'h0101_0202_0303_0404, 64'hA5A5_5A5A_F0F0_0F0F, 64'hDEAD_BEEF_CAFE_F00D, 64'h0000_0000_0000_0001};
    m1_ready = 1'b0;
    while (level1 != 5'd10 && cyc < 50) begin
      @(negedge clk);
      s1_valid = 1'b1;
      s1_data = 64'h0BAD_0000_0000_0000 + 64'(widx);
      #3;
      if (level1 != 5'd10 && s1_ready) widx++;
      cyc++;
    end
    checks++; if (level1 !== 5'd10) $display("FAIL pt_fill_level: got %0d expected 10", level1); else passed++;
    rst = 1'b0;
    #1;
    checks++; if (s1_ready !== 1'b0) $display("FAIL pt_rst_tready: got %b expected 0", s1_ready); else passed++;
    checks++; if (m1_valid !== 1'b0) $display("FAIL pt_rst_tvalid: got %b expected 0", m1_valid); else passed++;
    checks++; if (level1 !== 5'd0) $display("FAIL pt_rst_level: got %0d expected 0", level1); else passed++;
    checks++; if (m1_data !== 64'd0) $display("FAIL pt_rst_tdata: got %h expected 0", m1_data); else passed++;
    checks++; if ({m1_last, pkt_count1} !== 33'd0) $display("FAIL pt_rst_tlast_count: got %b/%0d expected 0/0", m1_last, pkt_count1); else passed++;
    s1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      m1_ready = 1'b1;
      s1_valid = (c < 4);
      s1_data = (c < 4) ? pw[c] : 64'd0;
      #3;
      if (c < 4) begin
        checks++; if (s1_ready !== 1'b1) $display("FAIL pt_tready_c%0d: got %b expected 1", c, s1_ready); else passed++;
      end
      if (c >= 2 && c <= 5) begin
        checks++;
        if ({m1_valid, m1_data} !== {1'b1, pw[c-2]})
          $display("FAIL pt_beat_c%0d: got v=%b d=%h expected v=1 d=%h", c, m1_valid, m1_data, pw[c-2]);
        else passed++;
      end else begin
        checks++; if (m1_valid !== 1'b0) $display("FAIL pt_idle_c%0d: tvalid got %b expected 0", c, m1_valid); else passed++;
      end
    end
    s1_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    s_data = '0; s_valid = 1'b0; m_ready = 1'b1; enable = 1'b1; flush = 1'b0; pkt_len = 16'd0;
    s1_data = '0; s1_valid = 1'b0; m1_ready = 1'b1; enable1 = 1'b1; flush1 = 1'b0; pkt_len1 = 16'd0;
    test_reset();
    test_single_word();
    test_enable();
    test_throughput();
    test_backpressure();
    test_framing();
    test_flush();
    test_reset_midstream();
    test_passthrough();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
